// File: rtl/store_checker_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | store_checker_pkg : shared state and failure-code encodings        |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_ADDR    = 3'd1,
    FC_DATA    = 3'd2,
    FC_TIMEOUT = 3'd3,
    FC_CONFIG  = 3'd4
  } fail_code_e;

endpackage
`default_nettype wire

// File: rtl/store_checker_exp_table.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | exp_table : expected-store register file with per-entry compares  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module exp_table #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int N_EXP = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    we_i,
  input  logic [$clog2(N_EXP > 1 ? N_EXP : 2)-1:0] idx_i,
  input  logic [AW-1:0]                           waddr_i,
  input  logic [DW-1:0]                           wdata_i,
  input  logic [AW-1:0]                           cmp_addr_i,
  input  logic [DW-1:0]                           cmp_data_i,
  output logic [N_EXP-1:0]                        addr_eq_o,
  output logic [N_EXP-1:0]                        data_eq_o
);

  localparam int IW = $clog2(N_EXP > 1 ? N_EXP : 2);

  for (genvar g = 0; g < N_EXP; g++) begin : g_entry
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        addr_q <= '0;
        data_q <= '0;
      end else if (we_i && (idx_i == IW'(g))) begin
        addr_q <= waddr_i;
        data_q <= wdata_i;
      end
    end

    assign addr_eq_o[g] = (addr_q == cmp_addr_i);
    assign data_eq_o[g] = (data_q == cmp_data_i);
  end

endmodule
`default_nettype wire

// File: rtl/store_checker.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | store_checker : checks a CPU store stream against an expected table|
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module store_checker
  import store_checker_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int N_EXP   = 4,
  parameter int TIMEOUT = 1000,
  parameter int ORDERED = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    exp_we,
  input  logic [$clog2(N_EXP > 1 ? N_EXP : 2)-1:0] exp_idx,
  input  logic [AW-1:0]                           exp_addr,
  input  logic [DW-1:0]                           exp_data,
  input  logic [$clog2(N_EXP+1)-1:0]              n_exp,
  input  logic [AW-1:0]                           ign_lo,
  input  logic [AW-1:0]                           ign_hi,
  input  logic                                    start,
  input  logic                                    memwrite,
  input  logic [AW-1:0]                           dataadr,
  input  logic [DW-1:0]                           writedata,
  output logic                                    done,
  output logic                                    pass,
  output logic [2:0]                              fail_code,
  output logic [$clog2(N_EXP+1)-1:0]              match_cnt,
  output logic [AW-1:0]                           fail_addr,
  output logic [DW-1:0]                           fail_data
);

  localparam int CW = $clog2(N_EXP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CYC_MAX = '1;

  state_e            state_q;
  logic [CW-1:0]     n_exp_q;
  logic [CW-1:0]     match_cnt_q;
  logic [N_EXP-1:0]  hit_q;
  logic [TW-1:0]     cyc_q;
  logic              done_q;
  logic              pass_q;
  logic [2:0]        fail_code_q;
  logic [AW-1:0]     fail_addr_q;
  logic [DW-1:0]     fail_data_q;

  logic [N_EXP-1:0]  addr_eq;
  logic [N_EXP-1:0]  data_eq;
  logic [N_EXP-1:0]  sel_ord;
  logic [N_EXP-1:0]  active;
  logic [N_EXP-1:0]  cand;
  logic [N_EXP-1:0]  addr_vec;
  logic [N_EXP-1:0]  match_vec;
  logic [N_EXP-1:0]  first_hit;
  logic              ign_hit;
  logic              store;
  logic              tbl_we;
  logic [CW-1:0]     cnt_inc;

  assign tbl_we  = exp_we && (state_q != ST_RUN);
  assign cnt_inc = match_cnt_q + CW'(1);

  exp_table #(
    .DW    (DW),
    .AW    (AW),
    .N_EXP (N_EXP)
  ) u_exp_table (
    .clk        (clk),
    .reset      (reset),
    .we_i       (tbl_we),
    .idx_i      (exp_idx),
    .waddr_i    (exp_addr),
    .wdata_i    (exp_data),
    .cmp_addr_i (dataadr),
    .cmp_data_i (writedata),
    .addr_eq_o  (addr_eq),
    .data_eq_o  (data_eq)
  );

  // Ordered mode considers only the next entry; unordered mode any active, unhit entry.
  always_comb begin
    ign_hit = (ign_lo <= ign_hi) && (dataadr >= ign_lo) && (dataadr <= ign_hi);
    store   = memwrite && !ign_hit;
    sel_ord = '0;
    active  = '0;
    for (int i = 0; i < N_EXP; i++) begin
      sel_ord[i] = (32'(match_cnt_q) == i);
      active[i]  = (32'(n_exp_q) > i);
    end
    cand      = (ORDERED != 0) ? sel_ord : (active & ~hit_q);
    addr_vec  = addr_eq & cand;
    match_vec = addr_vec & data_eq;
    first_hit = '0;
    for (int i = N_EXP - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        first_hit    = '0;
        first_hit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_exp_q     <= '0;
      match_cnt_q <= '0;
      hit_q       <= '0;
      cyc_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= FC_NONE;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cyc_q != CYC_MAX) cyc_q <= cyc_q + TW'(1);
          if (store && (|match_vec)) begin
            hit_q       <= hit_q | first_hit;
            match_cnt_q <= cnt_inc;
            if (cnt_inc == n_exp_q) begin
              state_q <= ST_PASS;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else if (cyc_q == TO_LAST) begin
              state_q     <= ST_FAIL;
              done_q      <= 1'b1;
              fail_code_q <= FC_TIMEOUT;
            end
          end else if (store) begin
            state_q     <= ST_FAIL;
            done_q      <= 1'b1;
            fail_code_q <= (|addr_vec) ? FC_DATA : FC_ADDR;
            fail_addr_q <= dataadr;
            fail_data_q <= writedata;
          end else if (cyc_q == TO_LAST) begin
            state_q     <= ST_FAIL;
            done_q      <= 1'b1;
            fail_code_q <= FC_TIMEOUT;
          end
        end
        default: begin
          if (start) begin
            n_exp_q     <= n_exp;
            match_cnt_q <= '0;
            hit_q       <= '0;
            cyc_q       <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            if ((n_exp == '0) || (32'(n_exp) > N_EXP)) begin
              state_q     <= ST_FAIL;
              done_q      <= 1'b1;
              fail_code_q <= FC_CONFIG;
            end else begin
              state_q     <= ST_RUN;
              done_q      <= 1'b0;
              fail_code_q <= FC_NONE;
            end
          end
        end
      endcase
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule
`default_nettype wire

// File: tb/tb_store_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_store_checker : ordered and unordered checkers vs. a reference  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_store_checker;

  localparam int N  = 4;
  localparam int TO = 50;
  localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exp_we = 1'b0;
  logic [1:0]  exp_idx = '0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic [2:0]  n_exp = '0;
  logic [31:0] ign_lo = 32'd1, ign_hi = 32'd0;
  logic        start = 1'b0, memwrite = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0;

  logic        done_o, pass_o, done_u, pass_u;
  logic [2:0]  code_o, code_u, cnt_o, cnt_u;
  logic [31:0] fa_o, fd_o, fa_u, fd_u;
  logic [71:0] out_o, out_u;

  assign out_o = {done_o, pass_o, code_o, cnt_o, fa_o, fd_o};
  assign out_u = {done_u, pass_u, code_u, cnt_u, fa_u, fd_u};

  always #5 clk = ~clk;

  store_checker #(.DW(32), .AW(32), .N_EXP(N), .TIMEOUT(TO), .ORDERED(1)) dut_o (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .n_exp(n_exp), .ign_lo(ign_lo), .ign_hi(ign_hi), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .done(done_o),
    .pass(pass_o), .fail_code(code_o), .match_cnt(cnt_o), .fail_addr(fa_o), .fail_data(fd_o)
  );

  store_checker #(.DW(32), .AW(32), .N_EXP(N), .TIMEOUT(TO), .ORDERED(0)) dut_u (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .n_exp(n_exp), .ign_lo(ign_lo), .ign_hi(ign_hi), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .done(done_u),
    .pass(pass_u), .fail_code(code_u), .match_cnt(cnt_u), .fail_addr(fa_u), .fail_data(fd_u)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: per-checker copy of the table and run bookkeeping.
  logic [31:0] tbl_a [2][N];
  logic [31:0] tbl_d [2][N];
  bit          hit   [2][N];
  int          m_st[2], m_cnt[2], m_n[2], m_cyc[2];
  logic [2:0]  m_code[2];
  logic [31:0] m_fa[2], m_fd[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        tbl_a[k][i] = '0; tbl_d[k][i] = '0; hit[k][i] = 1'b0;
      end
      m_st[k] = S_IDLE; m_cnt[k] = 0; m_n[k] = 0; m_cyc[k] = 0;
      m_code[k] = 3'd0; m_fa[k] = '0; m_fd[k] = '0;
    end
  endtask

  task automatic model_tick(int k, bit ord);
    int st;
    st = m_st[k];
    if (st == S_RUN) begin
      bit dec;
      dec = 1'b0;
      if (memwrite && !(ign_lo <= ign_hi && dataadr >= ign_lo && dataadr <= ign_hi)) begin
        int mi, ai;
        mi = -1; ai = -1;
        if (ord) begin
          if (tbl_a[k][m_cnt[k]] == dataadr) begin
            ai = m_cnt[k];
            if (tbl_d[k][ai] == writedata) mi = ai;
          end
        end else begin
          for (int i = 0; i < m_n[k]; i++) begin
            if (!hit[k][i] && tbl_a[k][i] == dataadr) begin
              if (ai < 0) ai = i;
              if (mi < 0 && tbl_d[k][i] == writedata) mi = i;
            end
          end
        end
        if (mi >= 0) begin
          hit[k][mi] = 1'b1;
          m_cnt[k]++;
          if (m_cnt[k] == m_n[k]) begin m_st[k] = S_PASS; dec = 1'b1; end
        end else begin
          m_st[k] = S_FAIL; dec = 1'b1;
          m_code[k] = (ai >= 0) ? 3'd2 : 3'd1;
          m_fa[k] = dataadr; m_fd[k] = writedata;
        end
      end
      if (!dec && m_cyc[k] == TO - 1) begin m_st[k] = S_FAIL; m_code[k] = 3'd3; end
      m_cyc[k]++;
    end else if (start) begin
      for (int i = 0; i < N; i++) hit[k][i] = 1'b0;
      m_cnt[k] = 0; m_cyc[k] = 0; m_fa[k] = '0; m_fd[k] = '0; m_n[k] = int'(n_exp);
      if (n_exp == 0 || int'(n_exp) > N) begin m_st[k] = S_FAIL; m_code[k] = 3'd4; end
      else begin m_st[k] = S_RUN; m_code[k] = 3'd0; end
    end
    if (exp_we && st != S_RUN) begin
      tbl_a[k][exp_idx] = exp_addr; tbl_d[k][exp_idx] = exp_data;
    end
  endtask

  function automatic logic [71:0] mvec(int k);
    logic [2:0] c;
    c = 3'(m_cnt[k]);
    return {(m_st[k] == S_PASS || m_st[k] == S_FAIL), (m_st[k] == S_PASS), m_code[k], c, m_fa[k], m_fd[k]};
  endfunction

  task automatic step();
    if (reset) model_reset();
    else begin model_tick(0, 1'b1); model_tick(1, 1'b0); end
    @(posedge clk); #1;
    chk("model_ord", out_o, mvec(0));
    chk("model_unord", out_u, mvec(1));
  endtask

  task automatic clr();
    start = 1'b0; memwrite = 1'b0; exp_we = 1'b0;
  endtask

  task automatic wr(int idx, logic [31:0] a, logic [31:0] d);
    exp_we = 1'b1; exp_idx = 2'(idx); exp_addr = a; exp_data = d;
    step();
    exp_we = 1'b0;
  endtask

  task automatic go(int n);
    start = 1'b1; n_exp = 3'(n);
    step();
    start = 1'b0;
  endtask

  task automatic st(logic [31:0] a, logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  typedef struct {
    logic st; logic [2:0] n; logic mw;
    logic [31:0] lo, hi, adr, wd;
    logic done, pass; logic [2:0] code, cnt; logic [31:0] fa, fd;
  } vec_t;
  vec_t vt[$];

  task automatic addv(logic s, int n, logic mw, int lo, int hi, int adr, int wd,
                      logic dn, logic ps, int code, int cnt, int fa, int fd);
    vec_t v;
    v.st = s; v.n = 3'(n); v.mw = mw; v.lo = lo; v.hi = hi; v.adr = adr; v.wd = wd;
    v.done = dn; v.pass = ps; v.code = 3'(code); v.cnt = 3'(cnt); v.fa = fa; v.fd = fd;
    vt.push_back(v);
  endtask

  int rise_o, rise_u;

  initial begin
    // start n mw  lo  hi  adr wd   done pass code cnt fa  fd   (table entry0 = 84,7)
    addv(1, 1, 0, 80, 80,  0, 0,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 80, 80, 80, 5,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 80, 80, 84, 7,   1, 1, 0, 1,  0, 0);
    addv(0, 1, 0, 80, 80,  0, 0,   1, 1, 0, 1,  0, 0);
    addv(0, 1, 1, 80, 80, 88, 7,   1, 1, 0, 1,  0, 0);
    addv(1, 1, 0, 80, 80,  0, 0,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 80, 80, 84, 6,   1, 0, 2, 0, 84, 6);
    addv(1, 1, 0, 80, 80,  0, 0,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 80, 80, 88, 7,   1, 0, 1, 0, 88, 7);
    addv(1, 0, 0, 80, 80,  0, 0,   1, 0, 4, 0,  0, 0);
    addv(1, 5, 0, 80, 80,  0, 0,   1, 0, 4, 0,  0, 0);
    addv(1, 1, 0, 80, 80,  0, 0,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 90, 80, 80, 5,   1, 0, 1, 0, 80, 5);
    addv(1, 1, 0, 80, 84,  0, 0,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 80, 84, 80, 5,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 80, 84, 84, 7,   0, 0, 0, 0,  0, 0);
    addv(0, 1, 1, 80, 84, 85, 7,   1, 0, 1, 0, 85, 7);

    step(); step();
    chk("reset_state_o", out_o, 72'h0);
    chk("reset_state_u", out_u, 72'h0);
    reset = 1'b0;

    wr(0, 32'd84, 32'd7);
    foreach (vt[v]) begin
      start = vt[v].st; n_exp = vt[v].n; memwrite = vt[v].mw; ign_lo = vt[v].lo;
      ign_hi = vt[v].hi; dataadr = vt[v].adr; writedata = vt[v].wd;
      step();
      chk($sformatf("vec%0d", v), out_o,
          {vt[v].done, vt[v].pass, vt[v].code, vt[v].cnt, vt[v].fa, vt[v].fd});
    end
    clr();

    // Out-of-order stores: unordered passes, ordered fails on the first one.
    ign_lo = 32'd1; ign_hi = 32'd0;
    wr(0, 32'd4, 32'd1);
    wr(1, 32'd8, 32'd2);
    go(2);
    st(32'd8, 32'd2);
    chk("ooo_ord_fail", {done_o, code_o, fa_o}, {1'b1, 3'd1, 32'd8});
    chk("ooo_unord_cnt", {done_u, cnt_u}, {1'b0, 3'd1});
    st(32'd4, 32'd1);
    chk("ooo_unord_pass", {done_u, pass_u, cnt_u}, {1'b1, 1'b1, 3'd2});

    // Reset in the middle of a run after one match.
    go(2);
    st(32'd4, 32'd1);
    chk("pre_reset_cnt", cnt_o, 72'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_o", {done_o, pass_o, cnt_o}, 72'd0);
    chk("async_reset_u", {done_u, pass_u, cnt_u}, 72'd0);
    step();
    reset = 1'b0;
    go(0);
    chk("config_fail", {done_o, pass_o, code_o}, {1'b1, 1'b0, 3'd4});
    go(1);
    st(32'd0, 32'd0);
    chk("cleared_table_pass", {pass_o, pass_u}, 72'b11);

    // Timeout latency with no stores.
    go(1);
    rise_o = -1; rise_u = -1;
    for (int c = 1; c <= TO + 10; c++) begin
      step();
      if (rise_o < 0 && done_o) rise_o = c;
      if (rise_u < 0 && done_u) rise_u = c;
    end
    chk("timeout_lat_o", 72'(rise_o), 72'(TO));
    chk("timeout_lat_u", 72'(rise_u), 72'(TO));
    chk("timeout_code", {code_o, code_u}, {3'd3, 3'd3});

    // Randomized runs against the model.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) wr(i, 32'($urandom_range(0, 7) * 4), 32'($urandom_range(0, 3)));
      ign_lo = 32'($urandom_range(0, 31));
      ign_hi = 32'($urandom_range(0, 31));
      go((r % 6 == 5) ? int'($urandom_range(0, 5)) : int'($urandom_range(1, 4)));
      for (int c = 0; c < TO + 6; c++) begin
        memwrite = ($urandom_range(0, 2) == 0);
        dataadr  = ($urandom_range(0, 3) != 0) ? tbl_a[0][$urandom_range(0, N - 1)]
                                               : 32'($urandom_range(0, 31));
        writedata = ($urandom_range(0, 3) != 0) ? tbl_d[0][$urandom_range(0, N - 1)]
                                                : 32'($urandom_range(0, 3));
        start  = ($urandom_range(0, 19) == 0);
        n_exp  = 3'($urandom_range(1, 4));
        exp_we = ($urandom_range(0, 9) == 0);
        exp_idx = 2'($urandom_range(0, 3));
        exp_addr = 32'($urandom_range(0, 31));
        exp_data = 32'($urandom_range(0, 3));
        step();
      end
      clr();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
